// File: rtl/eth_ctrl_pkg.sv
// Shared constants and state encodings for the Ethernet control mailbox responder.
package eth_ctrl_pkg;

  localparam int          CMD_WR_BIT      = 16;
  localparam int          CMD_RD_BIT      = 17;
  localparam logic [31:0] RD_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, WRITE, READ} mbx_state_t;

  typedef enum logic [1:0] {I_IDLE, I_RST, I_WAIT, I_DONE} init_state_t;

endpackage

// File: rtl/eth_ctrl_responder_if.sv
// Avalon-MM master bus between the mailbox responder and the MAC/PHY CSR space.
interface eth_ctrl_responder_if;

  logic [15:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );

endinterface

// File: rtl/eth_sync2.sv
// Two-flop synchronizer for a single level crossing into the management clock.
module eth_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // First stage may go metastable; second stage gives it a full cycle to settle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/eth_ctrl_responder.sv
// Mailbox responder: turns CSR command edges into single Avalon-MM transfers
// and sequences the PHY reset on request.
module eth_ctrl_responder #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int RST_CYCLES     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 eth_ctrl_addr,
  input  logic [31:0]                 eth_wr_data,
  output logic [31:0]                 eth_rd_data,
  input  logic                        init_start,
  output logic                        init_done,
  output logic                        phy_reset,
  input  logic                        phy_ready,
  eth_ctrl_responder_if.master        avm,
  output logic                        busy,
  output logic                        timeout_err
);

  import eth_ctrl_pkg::*;

  localparam int             TW     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam int             RW     = $clog2(RST_CYCLES) + 1;
  localparam logic [RW-1:0]  R_LAST = RW'(RST_CYCLES - 1);

  localparam int S_WR   = 0;
  localparam int S_RD   = 1;
  localparam int S_INIT = 2;

  logic [2:0] sync_in;
  logic [2:0] sync_q;
  logic [2:0] sync_prev;
  logic [2:0] rise;
  logic       init_fall;

  mbx_state_t  state;
  init_state_t init_state;
  logic        wr_pend;
  logic        rd_pend;
  logic [TW-1:0] wait_cnt;
  logic [RW-1:0] rst_cnt;

  // Upper command bits carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^eth_ctrl_addr[31:18];

  assign sync_in = {init_start, eth_ctrl_addr[CMD_RD_BIT], eth_ctrl_addr[CMD_WR_BIT]};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    eth_sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (sync_in[gi]),
      .q     (sync_q[gi])
    );
  end

  assign rise      = sync_q & ~sync_prev;
  assign init_fall = ~sync_q[S_INIT] & sync_prev[S_INIT];

  assign busy = wr_pend | rd_pend | (state != IDLE);

  // Previous synchronized levels, used to find rising/falling edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_prev <= 3'b000;
    else       sync_prev <= sync_q;
  end

  // Mailbox FSM: pending-request capture, launch, wait/timeout, completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      wr_pend           <= 1'b0;
      rd_pend           <= 1'b0;
      wait_cnt          <= '0;
      avm.avm_address   <= '0;
      avm.avm_writedata <= '0;
      avm.avm_read      <= 1'b0;
      avm.avm_write     <= 1'b0;
      eth_rd_data       <= '0;
      timeout_err       <= 1'b0;
    end else begin
      // A new edge while the same kind is pending simply merges into it.
      if (rise[S_WR]) wr_pend <= 1'b1;
      if (rise[S_RD]) rd_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (wr_pend || rd_pend) begin
            avm.avm_address   <= eth_ctrl_addr[15:0];
            avm.avm_writedata <= eth_wr_data;
            wait_cnt          <= '0;
            if (wr_pend) begin
              state         <= WRITE;
              avm.avm_write <= 1'b1;
              if (!rise[S_WR]) wr_pend <= 1'b0;
            end else begin
              state        <= READ;
              avm.avm_read <= 1'b1;
              if (!rise[S_RD]) rd_pend <= 1'b0;
            end
          end
        end
        WRITE, READ: begin
          if (!avm.avm_waitrequest) begin
            avm.avm_write <= 1'b0;
            avm.avm_read  <= 1'b0;
            state         <= IDLE;
            if (state == READ) eth_rd_data <= avm.avm_readdata;
          end else if (wait_cnt == T_LAST) begin
            avm.avm_write <= 1'b0;
            avm.avm_read  <= 1'b0;
            timeout_err   <= 1'b1;
            state         <= IDLE;
            if (state == READ) eth_rd_data <= RD_TIMEOUT_DATA;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Init FSM: PHY reset pulse, wait for PHY ready, report done; a falling
  // init_start aborts from anywhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_state <= I_IDLE;
      init_done  <= 1'b0;
      phy_reset  <= 1'b1;
      rst_cnt    <= '0;
    end else if (init_fall) begin
      init_state <= I_IDLE;
      init_done  <= 1'b0;
      phy_reset  <= 1'b0;
    end else begin
      case (init_state)
        I_IDLE: begin
          if (rise[S_INIT]) begin
            init_state <= I_RST;
            init_done  <= 1'b0;
            phy_reset  <= 1'b1;
            rst_cnt    <= '0;
          end
        end
        I_RST: begin
          if (rst_cnt == R_LAST) begin
            phy_reset  <= 1'b0;
            init_state <= I_WAIT;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        I_WAIT: begin
          if (phy_ready) begin
            init_state <= I_DONE;
            init_done  <= 1'b1;
          end
        end
        I_DONE: init_done <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_ctrl_responder.sv
// Scoreboard bench for eth_ctrl_responder: stimulus pushes expected Avalon
// transfers, a bus-slave/monitor process pops and checks them.
module tb_eth_ctrl_responder;

  import eth_ctrl_pkg::*;

  localparam int TMO  = 8;
  localparam int RSTC = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] eth_ctrl_addr = '0;
  logic [31:0] eth_wr_data = '0;
  logic [31:0] eth_rd_data;
  logic        init_start = 1'b0;
  logic        init_done;
  logic        phy_reset;
  logic        phy_ready = 1'b0;
  logic        busy;
  logic        timeout_err;

  eth_ctrl_responder_if bus ();

  eth_ctrl_responder #(.TIMEOUT_CYCLES(TMO), .RST_CYCLES(RSTC)) dut (
    .clk           (clk),
    .reset         (reset),
    .eth_ctrl_addr (eth_ctrl_addr),
    .eth_wr_data   (eth_wr_data),
    .eth_rd_data   (eth_rd_data),
    .init_start    (init_start),
    .init_done     (init_done),
    .phy_reset     (phy_reset),
    .phy_ready     (phy_ready),
    .avm           (bus),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_rd;
    logic [15:0] addr;
    logic [31:0] data;
    int          stall;
    logic        tmo;
    int          launch;
    logic        rd_forced;
    logic [31:0] rdata;
  } xfer_t;

  xfer_t       expq[$];
  logic        in_xfer = 1'b0;
  int          hcnt = 0;
  logic        rd_chk_pend = 1'b0;
  logic [31:0] rd_chk_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Avalon slave model + monitor: decides waitrequest for the next edge and
  // checks each transfer against the front of the expectation queue.
  initial begin
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_xfer = 1'b0;
        hcnt = 0;
        rd_chk_pend = 1'b0;
        bus.avm_waitrequest = 1'b0;
      end else begin
        if (rd_chk_pend) begin
          chk("rd_data", eth_rd_data, rd_chk_val);
          rd_chk_pend = 1'b0;
        end
        if (bus.avm_read || bus.avm_write) begin
          chk("one_strobe", 32'(bus.avm_read & bus.avm_write), 32'd0);
          chk("xfer_expected", 32'(expq.size() != 0), 32'd1);
          if (expq.size() == 0) begin
            bus.avm_waitrequest = 1'b0;
          end else begin
            if (!in_xfer) begin
              in_xfer = 1'b1;
              hcnt = 0;
              chk("launch_cyc", cyc, expq[0].launch);
              chk("kind_rd", 32'(bus.avm_read), 32'(expq[0].is_rd));
              chk("address", 32'(bus.avm_address), 32'(expq[0].addr));
              if (!expq[0].is_rd) chk("writedata", bus.avm_writedata, expq[0].data);
            end
            hcnt++;
            if (expq[0].tmo || hcnt <= expq[0].stall) begin
              bus.avm_waitrequest = 1'b1;
              bus.avm_readdata = $urandom;
            end else begin
              bus.avm_waitrequest = 1'b0;
              bus.avm_readdata = expq[0].rd_forced ? expq[0].rdata : $urandom;
              if (expq[0].is_rd) begin
                rd_chk_pend = 1'b1;
                rd_chk_val = bus.avm_readdata;
              end
              $display("xfer %s addr=%h wdata=%h rdata=%h stalls=%0d", expq[0].is_rd ? "RD" : "WR",
                       expq[0].addr, expq[0].data, bus.avm_readdata, expq[0].stall);
              void'(expq.pop_front());
              in_xfer = 1'b0;
            end
          end
        end else begin
          if (in_xfer && expq.size() != 0) begin
            chk("tmo_expected", 32'(expq[0].tmo), 32'd1);
            if (expq[0].tmo) begin
              chk("tmo_len", hcnt, TMO);
              chk("tmo_flag", 32'(timeout_err), 32'd1);
              if (expq[0].is_rd) chk("tmo_rd_data", eth_rd_data, RD_TIMEOUT_DATA);
              $display("xfer %s addr=%h timed out after %0d cycles", expq[0].is_rd ? "RD" : "WR",
                       expq[0].addr, hcnt);
            end
            void'(expq.pop_front());
          end
          in_xfer = 1'b0;
          bus.avm_waitrequest = 1'($urandom);
          bus.avm_readdata = $urandom;
        end
      end
    end
  end

  // Issue one command (write, read, or both together) and wait for it to drain.
  task automatic issue(input logic wr, input logic rd, input logic [15:0] a, input logic [31:0] d,
                       input int sw, input int sr, input logic tw, input logic tr,
                       input logic rf, input logic [31:0] rv);
    xfer_t it;
    int k;
    int l;
    int n;
    @(posedge clk);
    #1;
    k = cyc;
    l = k + 4;
    if (wr) begin
      it.is_rd = 1'b0; it.addr = a; it.data = d; it.stall = sw; it.tmo = tw;
      it.launch = l; it.rd_forced = 1'b0; it.rdata = '0;
      expq.push_back(it);
      l = l + (tw ? TMO : sw + 1) + 1;
    end
    if (rd) begin
      it.is_rd = 1'b1; it.addr = a; it.data = d; it.stall = sr; it.tmo = tr;
      it.launch = l; it.rd_forced = rf; it.rdata = rv;
      expq.push_back(it);
    end
    eth_ctrl_addr = {14'($urandom), rd, wr, a};
    eth_wr_data   = d;
    @(posedge clk);
    @(posedge clk);
    #1;
    eth_ctrl_addr[17:16] = 2'b00;
    @(posedge clk);
    #1;
    chk("busy_set", 32'(busy), 32'd1);
    n = 0;
    while ((busy || expq.size() != 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drained", 32'(n < 300), 32'd1);
    if (n >= 300) expq.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int k;
    xfer_t it;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_data", eth_rd_data, 32'd0);
    chk("rst_avm_read", 32'(bus.avm_read), 32'd0);
    chk("rst_avm_write", 32'(bus.avm_write), 32'd0);
    chk("rst_avm_addr", 32'(bus.avm_address), 32'd0);
    chk("rst_avm_wdata", bus.avm_writedata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_phy_reset", 32'(phy_reset), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Directed cases
    issue(1'b1, 1'b0, 16'h0123, 32'hA5A5_5A5A, 0, 0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    issue(1'b0, 1'b1, 16'h0040, 32'd0, 0, 5, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
    chk("rd_result", eth_rd_data, 32'h1234_5678);
    issue(1'b1, 1'b1, 16'h0200, 32'hCAFE_F00D, 0, 0, 1'b0, 1'b0, 1'b1, 32'h5555_AAAA);
    chk("both_rd_result", eth_rd_data, 32'h5555_AAAA);
    chk("tmo_clear", 32'(timeout_err), 32'd0);
    issue(1'b0, 1'b1, 16'h0077, 32'd0, 0, 0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk("tmo_set", 32'(timeout_err), 32'd1);
    chk("tmo_deadbeef", eth_rd_data, 32'hDEAD_BEEF);
    issue(1'b0, 1'b1, 16'h0078, 32'd0, 0, 2, 1'b0, 1'b0, 1'b1, 32'h0BAD_F00D);
    chk("after_tmo_rd", eth_rd_data, 32'h0BAD_F00D);
    chk("tmo_sticky", 32'(timeout_err), 32'd1);

    // Randomized commands
    for (int i = 0; i < 24; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      issue(kind != 1, kind != 0, 16'($urandom), $urandom,
            $urandom_range(0, 5), $urandom_range(0, 5),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, 1'b0, 32'd0);
    end

    // Init sequence
    @(posedge clk);
    #1;
    k = cyc;
    init_start = 1'b1;
    repeat (18) @(posedge clk);
    #1;
    chk("phy_rst_hold", 32'(phy_reset), 32'd1);
    @(posedge clk);
    #1;
    chk("phy_rst_rel", 32'(phy_reset), 32'd0);
    chk("phy_rst_cyc", cyc - k, 3 + RSTC);
    repeat (4) @(posedge clk);
    #1;
    chk("init_wait", 32'(init_done), 32'd0);
    phy_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("init_done", 32'(init_done), 32'd1);
    $display("init done at cycle %0d", cyc);
    repeat (3) @(posedge clk);
    #1;
    init_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_done_hold", 32'(init_done), 32'd1);
    @(posedge clk);
    #1;
    chk("init_done_clr", 32'(init_done), 32'd0);
    chk("phy_rst_low", 32'(phy_reset), 32'd0);
    phy_ready = 1'b0;
    repeat (3) @(posedge clk);

    // Reset during a stalled write
    @(posedge clk);
    #1;
    k = cyc;
    it.is_rd = 1'b0; it.addr = 16'h0ABC; it.data = 32'h1357_9BDF; it.stall = 0; it.tmo = 1'b1;
    it.launch = k + 4; it.rd_forced = 1'b0; it.rdata = '0;
    expq.push_back(it);
    eth_ctrl_addr = {14'd0, 2'b01, 16'h0ABC};
    eth_wr_data   = 32'h1357_9BDF;
    @(posedge clk);
    @(posedge clk);
    #1;
    eth_ctrl_addr[17:16] = 2'b00;
    n = 0;
    while (!bus.avm_write && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobe_seen", 32'(bus.avm_write), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_drop", 32'(bus.avm_write), 32'd0);
    chk("rst_phy_high", 32'(phy_reset), 32'd1);
    chk("rst_busy_clr", 32'(busy), 32'd0);
    expq.delete();
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_write", 32'(bus.avm_write), 32'd0);
    chk("post_rst_read", 32'(bus.avm_read), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_tmo", 32'(timeout_err), 32'd0);
    chk("post_rst_rd_data", eth_rd_data, 32'd0);
    chk("post_rst_phy", 32'(phy_reset), 32'd1);
    chk("queue_empty", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
